// File: rtl/voltage_pkg.sv
// Shared definitions for the voltage-to-BCD converter: FSM state encoding,
// width derivation helpers and the BCD nibble width.
package voltage_pkg;

  localparam int BCD_NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    CONV  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to hold 0..fs_mv inclusive.
  function automatic int mv_width(input int fs_mv);
    return $clog2(fs_mv + 1);
  endfunction

  // Channel tag width; at least one bit even for a single channel.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // 10**n for sizing the largest value NDIG decimal digits can show.
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Add-3 correction for digits 5..15.
  always_comb begin
    q = (d >= 4'd5) ? (d + 4'd3) : d;
  end

endmodule

// File: rtl/voltage_bcd_converter.sv
// Converts a raw ADC code to millivolts and then to NDIG packed BCD digits.
// One conversion at a time: IDLE accepts, SCALE multiplies, CONV runs one
// double-dabble bit per cycle then latches the result, DONE holds it until the
// consumer takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds its data stable while valid is high and not ready.
// Build option: define VOLTAGE_BCD_ROUND_EN to round the scaled value half-up
// instead of truncating; timing is unchanged.
module voltage_bcd_converter
  import voltage_pkg::*;
#(
  parameter  int ADC_W = 12,
  parameter  int FS_MV = 5000,
  parameter  int NDIG  = 4,
  parameter  int NCH   = 4,
  localparam int CH_W  = ch_width(NCH),
  localparam int MV_W  = mv_width(FS_MV)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADC_W-1:0]          in_code,
  input  logic [CH_W-1:0]           in_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_chan,
  output logic [MV_W-1:0]           out_mv,
  output logic [BCD_NIB_W*NDIG-1:0] out_bcd,
  output logic                      out_ovf
);

`ifdef VOLTAGE_BCD_ROUND_EN
  localparam int PROD_W = ADC_W + MV_W + 1;
`else
  localparam int PROD_W = ADC_W + MV_W;
`endif
  localparam int BCD_W = BCD_NIB_W * NDIG;
  localparam int CNT_W = $clog2(MV_W + 1);
  localparam int unsigned BCD_MAX = pow10(NDIG) - 1;
  localparam logic [BCD_W-1:0] ALL_NINES = {NDIG{4'h9}};

  state_e state_q, state_d;

  logic [ADC_W-1:0]  code_q;
  logic [CH_W-1:0]   chan_q;
  logic [MV_W-1:0]   mv_q;
  logic [MV_W-1:0]   sh_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] prod;
  logic [MV_W-1:0]   mv_scaled;
  logic              ovf;

  logic [CH_W-1:0]   res_chan;
  logic [MV_W-1:0]   res_mv;
  logic [BCD_W-1:0]  res_bcd;
  logic              res_ovf;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_dabble_digit u_dig (
      .d (bcd_q  [g*BCD_NIB_W +: BCD_NIB_W]),
      .q (bcd_adj[g*BCD_NIB_W +: BCD_NIB_W])
    );
  end

  // Scale the latched code to millivolts (optionally rounded half-up).
  always_comb begin
    prod = PROD_W'(code_q) * PROD_W'(FS_MV);
`ifdef VOLTAGE_BCD_ROUND_EN
    prod = prod + (PROD_W'(1) << (ADC_W - 1));
`endif
    mv_scaled = MV_W'(prod >> ADC_W);
  end

  // Value too large for NDIG digits.
  always_comb begin
    ovf = (32'(mv_q) > BCD_MAX);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = SCALE;
      SCALE:                        state_d = CONV;
      CONV:    if (cnt_q == '0)     state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs; in_ready stays low while reset is held.
  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: latch input, scale, shift-and-correct, then capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= '0;
      chan_q   <= '0;
      mv_q     <= '0;
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      res_chan <= '0;
      res_mv   <= '0;
      res_bcd  <= '0;
      res_ovf  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            code_q <= in_code;
            chan_q <= in_chan;
          end
        end
        SCALE: begin
          mv_q  <= mv_scaled;
          sh_q  <= mv_scaled;
          bcd_q <= '0;
          cnt_q <= CNT_W'(MV_W);
        end
        CONV: begin
          if (cnt_q != '0) begin
            bcd_q <= {bcd_adj[BCD_W-2:0], sh_q[MV_W-1]};
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            res_chan <= chan_q;
            res_mv   <= mv_q;
            res_ovf  <= ovf;
            res_bcd  <= ovf ? ALL_NINES : bcd_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs come straight from the captured registers.
  always_comb begin
    out_chan = res_chan;
    out_mv   = res_mv;
    out_bcd  = res_bcd;
    out_ovf  = res_ovf;
  end

endmodule

// File: tb/tb_voltage_bcd_converter.sv
// Bench for voltage_bcd_converter: a default 4-digit instance and a 3-digit
// instance share clock, reset and inputs, so each vector checks both.
module tb_voltage_bcd_converter;
  import voltage_pkg::*;

  localparam int ADC_W = 12;
  localparam int FS_MV = 5000;
  localparam int NCH   = 4;
  localparam int CH_W  = ch_width(NCH);
  localparam int MV_W  = mv_width(FS_MV);
  localparam int EW    = CH_W + 2 + MV_W + 16 + 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADC_W-1:0]  in_code = '0;
  logic [CH_W-1:0]   in_chan = '0;

  logic              in_ready, out_valid, out_ovf;
  logic [CH_W-1:0]   out_chan;
  logic [MV_W-1:0]   out_mv;
  logic [15:0]       out_bcd;

  logic              in_ready3, out_valid3, out_ovf3;
  logic [CH_W-1:0]   out_chan3;
  logic [MV_W-1:0]   out_mv3;
  logic [11:0]       out_bcd3;

  logic [EW-1:0]     exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;

  voltage_bcd_converter #(.ADC_W(ADC_W), .FS_MV(FS_MV), .NDIG(4), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_chan(in_chan), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan), .out_mv(out_mv),
    .out_bcd(out_bcd), .out_ovf(out_ovf)
  );

  voltage_bcd_converter #(.ADC_W(ADC_W), .FS_MV(FS_MV), .NDIG(3), .NCH(NCH)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_code(in_code), .in_chan(in_chan), .out_valid(out_valid3),
    .out_ready(out_ready), .out_chan(out_chan3), .out_mv(out_mv3),
    .out_bcd(out_bcd3), .out_ovf(out_ovf3)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog in case something stalls beyond every bounded loop.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: millivolts by integer division, digits by repeated /10.
  function automatic logic [EW-1:0] model(input logic [ADC_W-1:0] code, input logic [CH_W-1:0] chan);
    int          mv, v4, v3;
    logic        o4, o3;
    logic [15:0] b4;
    logic [11:0] b3;
`ifdef VOLTAGE_BCD_ROUND_EN
    mv = (int'(code) * FS_MV + 2048) / 4096;
`else
    mv = (int'(code) * FS_MV) / 4096;
`endif
    o4 = (mv > 9999);
    o3 = (mv > 999);
    v4 = o4 ? 9999 : mv;
    v3 = o3 ? 999 : mv;
    for (int d = 0; d < 4; d++) b4[4*d +: 4] = 4'((v4 / (10 ** d)) % 10);
    for (int d = 0; d < 3; d++) b3[4*d +: 4] = 4'((v3 / (10 ** d)) % 10);
    return {chan, o4, o3, MV_W'(mv), b4, b3};
  endfunction

  // Compare both instances' result outputs against one expected entry.
  task automatic check_result(input string tag, input logic [EW-1:0] e);
    check({tag, "_chan"},  out_chan,  e[EW-1 -: CH_W]);
    check({tag, "_ovf4"},  out_ovf,   e[EW-CH_W-1]);
    check({tag, "_mv"},    out_mv,    e[40 -: MV_W]);
    check({tag, "_bcd4"},  out_bcd,   e[27:12]);
    check({tag, "_chan3"}, out_chan3, e[EW-1 -: CH_W]);
    check({tag, "_ovf3"},  out_ovf3,  e[EW-CH_W-2]);
    check({tag, "_mv3"},   out_mv3,   e[40 -: MV_W]);
    check({tag, "_bcd3"},  out_bcd3,  e[11:0]);
  endtask

  // Driver: offer one sample, follow it through to the consumer handshake.
  task automatic do_convert(input logic [ADC_W-1:0] code, input logic [CH_W-1:0] chan, input int stall);
    int            n;
    logic [EW-1:0] e;
    exp_q.push_back(model(code, chan));
    in_code  = code;
    in_chan  = chan;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = ADC_W'($urandom);
    in_chan  = CH_W'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!out_valid) begin
        check("busy_in_ready", in_ready, 1'b0);
        in_valid  = 1'($urandom_range(0, 1));
        in_code   = ADC_W'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
    end while (!out_valid && n < 100);
    out_ready = 1'b0;
    check("latency", n, MV_W + 2);
    check("valid3", out_valid3, 1'b1);
    e = exp_q.pop_front();
    check_result("result", e);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_code  = ADC_W'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check_result("hold", e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1'b1);
    check("release_valid", out_valid, 1'b0);
    check("release_in_ready3", in_ready3, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,  1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check_result(tag, '0);
    check({tag, "_out_valid3"}, out_valid3, 1'b0);
  endtask

  // Main sequence.
  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    do_convert(12'h800, 2'd0, 0);
    do_convert(12'hFFF, 2'd1, 0);
    do_convert(12'h000, 2'd3, 0);
    do_convert(12'h001, 2'd3, 0);
    do_convert(12'hFFF, 2'd2, 10);

    // Leave a non-zero result behind, then reset in the middle of CONV.
    do_convert(12'hFFF, 2'd3, 0);
    in_code  = 12'h123;
    in_chan  = 2'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_conv_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_in_ready", in_ready, 1'b1);
    do_convert(12'h800, 2'd2, 0);

    for (int i = 0; i < 40; i++) begin
      logic [ADC_W-1:0] c;
      case ($urandom_range(0, 7))
        0:       c = 12'hFFF;
        1:       c = 12'h000;
        default: c = ADC_W'($urandom_range(0, 4095));
      endcase
      do_convert(c, CH_W'($urandom_range(0, NCH - 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
